// File: rtl/fp_pkg.sv
// Shared constants, types and helpers for the float reduction path.
package fp_pkg;

  localparam int          DW         = 32;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam int          FP_LAT_ADD = 2;

  typedef enum logic [1:0] {ACC, DRAIN, OUT} state_e;

  // Aligned-and-summed operand pair between the two adder stages
  typedef struct packed {
    logic        nan;
    logic        inf;
    logic        inf_sgn;
    logic        sgn;
    logic        zsgn;
    logic [7:0]  exp;
    logic [27:0] sum;
  } add_s1_t;

  function automatic int unsigned popcnt(input logic [FP_LAT_ADD-1:0] v);
    popcnt = 0;
    for (int i = 0; i < FP_LAT_ADD; i++) if (v[i]) popcnt++;
  endfunction

endpackage

// File: rtl/fp_sum_reducer_if.sv
// Input element stream and output sum stream of the reducer.
interface fp_sum_reducer_if #(parameter int W = 32);
  logic         in_vld, in_rdy, in_lst;
  logic [W-1:0] in_dat;
  logic         out_vld, out_rdy;
  logic [W-1:0] out_dat;

  modport master (output in_vld, in_dat, in_lst, out_rdy,
                  input  in_rdy, out_vld, out_dat);
  modport slave  (input  in_vld, in_dat, in_lst, out_rdy,
                  output in_rdy, out_vld, out_dat);
endinterface

// File: rtl/fp_sum_reducer_fpadd.sv
// Pipelined IEEE-754 single adder, round-to-nearest-even, denormals kept.
// RI/RP/RO select input / mid / output registers; OP="SUB" negates y.
module fpadd
  import fp_pkg::*;
#(
  parameter int    RI = 0,
  parameter int    RP = 1,
  parameter int    RO = 1,
  parameter string OP = "ADD"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] r
);

  logic [31:0] a_in, b_in, ya, big, sml, res;
  logic [7:0]  eb, es, d;
  logic [23:0] mb, ms;
  logic [26:0] mbx, msx, m2;
  logic        stk, a_inf, y_inf, up;
  logic [9:0]  e2, sh;
  logic [4:0]  lz;
  logic [24:0] mr;
  add_s1_t     s1_d, s1_q;

  if (RI != 0) begin : g_ri
    logic [31:0] x_q, y_q;
    // Optional input register
    always_ff @(posedge clk) begin
      if (rst) begin
        x_q <= '0;
        y_q <= '0;
      end else if (ena) begin
        x_q <= x;
        y_q <= y;
      end
    end
    assign a_in = x_q;
    assign b_in = y_q;
  end else begin : g_ri_n
    assign a_in = x;
    assign b_in = y;
  end

  // Stage 1: specials, magnitude swap, alignment with sticky, add/sub
  always_comb begin
    ya    = (OP == "SUB") ? {~b_in[31], b_in[30:0]} : b_in;
    a_inf = (&a_in[30:23]) && !(|a_in[22:0]);
    y_inf = (&ya[30:23]) && !(|ya[22:0]);
    if (a_in[30:0] >= ya[30:0]) begin
      big = a_in;
      sml = ya;
    end else begin
      big = ya;
      sml = a_in;
    end
    eb  = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    es  = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mb  = {big[30:23] != 8'd0, big[22:0]};
    ms  = {sml[30:23] != 8'd0, sml[22:0]};
    mbx = {mb, 3'b000};
    msx = {ms, 3'b000};
    d   = eb - es;
    if (d >= 8'd27) begin
      stk = |msx;
      msx = '0;
    end else begin
      stk = |(msx & ((27'd1 << d) - 27'd1));
      msx = msx >> d;
    end
    msx[0] = msx[0] | stk;
    s1_d         = '0;
    s1_d.sgn     = big[31];
    s1_d.zsgn    = big[31] & sml[31];
    s1_d.exp     = eb;
    s1_d.sum     = (big[31] == sml[31]) ? ({1'b0, mbx} + {1'b0, msx})
                                        : ({1'b0, mbx} - {1'b0, msx});
    s1_d.nan     = ((&a_in[30:23]) && (|a_in[22:0])) ||
                   ((&ya[30:23]) && (|ya[22:0])) ||
                   (a_inf && y_inf && (a_in[31] != ya[31]));
    s1_d.inf     = a_inf || y_inf;
    s1_d.inf_sgn = a_inf ? a_in[31] : ya[31];
  end

  if (RP != 0) begin : g_rp
    // Mid-pipeline register
    always_ff @(posedge clk) begin
      if (rst)      s1_q <= '0;
      else if (ena) s1_q <= s1_d;
    end
  end else begin : g_rp_n
    assign s1_q = s1_d;
  end

  // Stage 2: normalise (never below the denormal exponent), round, pack
  always_comb begin
    e2 = {2'b00, s1_q.exp};
    if (s1_q.sum[27]) begin
      m2 = {s1_q.sum[27:2], s1_q.sum[1] | s1_q.sum[0]};
      e2 = e2 + 10'd1;
    end else begin
      m2 = s1_q.sum[26:0];
    end
    lz = 5'd27;
    for (int i = 0; i < 27; i++) if (m2[i]) lz = 5'(26 - i);
    sh = ({5'b0, lz} > (e2 - 10'd1)) ? (e2 - 10'd1) : {5'b0, lz};
    m2 = m2 << sh;
    e2 = e2 - sh;
    up = m2[2] & (m2[3] | m2[1] | m2[0]);
    mr = {1'b0, m2[26:3]} + {24'b0, up};
    if (mr[24]) begin
      e2 = e2 + 10'd1;
      mr = mr >> 1;
    end
    if (s1_q.nan)               res = FP_QNAN;
    else if (s1_q.inf)          res = {s1_q.inf_sgn, 8'hFF, 23'b0};
    else if (m2 == 27'd0)       res = {s1_q.zsgn, 31'b0};
    else if (e2 >= 10'd255)     res = {s1_q.sgn, 8'hFF, 23'b0};
    else                        res = {s1_q.sgn, mr[23] ? e2[7:0] : 8'h00, mr[22:0]};
  end

  if (RO != 0) begin : g_ro
    logic [31:0] r_q;
    // Output register
    always_ff @(posedge clk) begin
      if (rst)      r_q <= '0;
      else if (ena) r_q <= res;
    end
    assign r = r_q;
  end else begin : g_ro_n
    assign r = res;
  end

endmodule

// File: rtl/fp_sum_reducer.sv
// Streaming float vector sum: up to LAT partial sums circulate through one
// pipelined adder, then are paired off in DRAIN until a single sum remains.
module fp_sum_reducer
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  fp_sum_reducer_if.slave   bus
);

  localparam int LAT = FP_LAT_ADD;

  state_e            state_q, state_d;
  logic [LAT-1:0]    occ_q, occ_d;
  logic [DW-1:0]     hold_q, hold_d, out_dat_q, out_dat_d;
  logic              hold_vld_q, hold_vld_d, out_vld_q, out_vld_d;
  logic [DW-1:0]     add_r, ret_dat, opnd;
  logic              ret_occ, iss_occ, in_rdy, xfer;
  int unsigned       inflight;

  assign ret_occ     = occ_q[LAT-1];
  assign ret_dat     = ret_occ ? add_r : FP_ZERO;
  assign in_rdy      = (state_q == ACC) && !rst;
  assign xfer        = bus.in_vld && in_rdy;
  assign bus.in_rdy  = in_rdy;
  assign bus.out_vld = out_vld_q;
  assign bus.out_dat = out_dat_q;

  fpadd #(.RI(0), .RP(1), .RO(1), .OP("ADD")) u_add (
    .clk (clk),
    .rst (rst),
    .ena (1'b1),
    .x   (ret_dat),
    .y   (opnd),
    .r   (add_r)
  );

  // Next state, adder operand selection and occupancy tracking
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    out_dat_d  = out_dat_q;
    out_vld_d  = out_vld_q;
    opnd       = FP_ZERO;
    iss_occ    = 1'b0;
    case (state_q)
      ACC: begin
        if (xfer) opnd = bus.in_dat;
        iss_occ = xfer || ret_occ;
        if (xfer && bus.in_lst) state_d = DRAIN;
      end
      DRAIN: begin
        if (ret_occ && !hold_vld_q) begin
          hold_d     = ret_dat;
          hold_vld_d = 1'b1;
        end else if (ret_occ) begin
          opnd       = hold_q;
          iss_occ    = 1'b1;
          hold_vld_d = 1'b0;
        end
      end
      OUT: begin
        if (bus.out_rdy) begin
          out_vld_d  = 1'b0;
          hold_vld_d = 1'b0;
          state_d    = ACC;
        end
      end
      default: state_d = ACC;
    endcase
    occ_d    = {occ_q[LAT-2:0], iss_occ};
    inflight = popcnt(occ_d);
    // Last partial captured with nothing left in the adder: sum is final
    if (state_q == DRAIN && inflight == 0 && hold_vld_d) begin
      state_d   = OUT;
      out_vld_d = 1'b1;
      out_dat_d = hold_d;
    end
  end

  // State, occupancy, hold and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      occ_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
    end
  end

endmodule

// File: doc/fp_sum_reducer.md
Name: fp_sum_reducer

Overview:
- Streaming single-precision reduction engine.
- Accepts a valid/ready stream of DW-bit floats, delimited by a last flag, and returns one sum per vector.
- Drives one existing pipelined fpadd instance as its arithmetic core: it issues operand pairs to the adder and consumes the adder's delayed results.
- Sits after the LUT-distance fetch in the HPQ search path and produces the per-candidate accumulated distance.

Parameters:
- DW, 32, float datawidth; only 32 is supported.
- LAT, 2, fpadd issue-to-result latency in cycles. Fixed by the fpadd build: RI=0, RP=1, RO=1, OP="ADD".

Ports:
- clk  in  1  global clock.
- rst  in  1  synchronous active-high reset. Also drives the fpadd rst pin.
- in_vld  in  1  input element valid.
- in_rdy  out  1  input ready; an element transfers when in_vld && in_rdy.
- in_dat  in  DW  input float.
- in_lst  in  1  marks the last element of a vector; sampled on transfer.
- out_vld  out  1  sum valid.
- out_rdy  in  1  downstream ready; the sum transfers when out_vld && out_rdy.
- out_dat  out  DW  vector sum.

Behaviour:
- **Reset.** On reset: state=ACC, in_rdy=0 during reset and 1 from the first cycle after, out_vld=0, out_dat=0, hold empty, all lane-occupancy bits cleared. fpadd pipeline contents are don't-care because validity is tracked only by the occupancy shift register.
- **Adder issue.** The fpadd is fed every cycle with ena=1, x=ret_dat and y=opnd.
  - ret_dat is the fpadd output r when the returning lane's occ bit is 1, else +0.0 (32'h0).
  - opnd is chosen per state, as below.
  - occ is a LAT-deep shift register that travels with the adder pipeline; ret_occ is its output.
- **State ACC** (in_rdy=1):
  - opnd = in_dat on transfer, else +0.0.
  - Issued occ bit = transfer || ret_occ. At most LAT partial sums circulate, and lane i holds the sum of elements whose issue slot equals i mod LAT.
  - A transfer with in_lst=1 moves to DRAIN next cycle.
- **State DRAIN** (in_rdy=0), per cycle:
  - ret_occ=1 and hold empty: capture r into hold; issue nothing (occ=0).
  - ret_occ=1 and hold full: issue (r, hold); clear hold; issued occ=1.
  - ret_occ=0: issue nothing.
  - inflight==0 and hold full: move to OUT and load out_dat<=hold.
  - inflight is the popcount of the occ shift register, including the slot issued this cycle.
- **State OUT** (in_rdy=0): out_vld=1 with out_dat stable.
  - On out_rdy: out_vld<=0, hold cleared, next state ACC.
  - out_vld never drops without a transfer.
- **Latency.** Elements accept at 1/cycle with no bubbles. From the last-element transfer at cycle t, out_vld rises by t + 2*LAT*(ceil(log2 LAT)+1) + 2 cycles; this is 10 for LAT=2.
- **Numerics.**
  - The association order is deterministic but is not the sequential order. Results match a sequential sum only where rounding is order-independent.
  - A single -0.0 element returns +0.0, since -0 + +0 = +0.
  - NaN/Inf propagate per the fpadd.
- **Boundaries.**
  - A vector of length 1 is legal.
  - There is no length limit; partials never overflow count because LAT bounds the number of lanes.
  - in_vld is ignored outside ACC.
  - rst in any state returns to the reset values on the next edge. A partially reduced vector is discarded and no out_vld is produced for it.
  - Back-to-back vectors: the first element of the next vector is accepted the cycle after the out transfer.

Decomposition:
- Shared package fp_pkg holds:
  - FP_ZERO = 32'h0000_0000.
  - FP_LAT_ADD = 2, the latency of the standard fpadd build.
  - The state enum {ACC, DRAIN, OUT}.
- Sub-module: the existing fpadd, instantiated once with RI=0, RP=1, RO=1, OP="ADD".
- The occupancy shift register and the FSM stay inline.

Test Plan:
- **Single element.** One element 0x40400000 (3.0) with in_lst=1 -> one out transfer of 0x40400000, out_vld within 10 cycles.
- **Back-to-back vector.** 1.0, 2.0, 3.0, 4.0 back-to-back (0x3F800000, 0x40000000, 0x40400000, 0x40800000), last on 4.0 -> 0x41200000 (10.0); in_rdy stays 1 for all four transfers.
- **Gapped vector.** Same values with in_vld low for 1-3 random cycles between elements -> 0x41200000, identical to the gap-free case.
- **Downstream backpressure.** out_rdy held 0 for 20 cycles on result 10.0 -> out_vld and out_dat held stable, in_rdy=0 throughout; release -> transfer, then in_rdy=1 the next cycle.
- **Reset mid-drain.** rst asserted in DRAIN after 7.0, 8.0 -> no output for that vector; then vector 5.0, 6.0 -> 0x41300000 (11.0).
- **Back-to-back vectors.** Three vectors {1.0}, {2.0, 2.0}, {0.5 ×8} with out_rdy=1 -> outputs 0x3F800000, 0x40800000, 0x40800000 in order, with no lost or extra transfers.
